// File: rtl/dispatch_mport.sv
// Steers whole 134-bit packets from execute to one of PORT_NUM output streams, discarding bad heads.
// Optional statistics counters are built only when DISPATCH_CNT_EN is defined.
module dispatch_mport #(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned DIR_W    = 2,
    parameter int unsigned DATA_W   = 134
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exe2disp_data_wr,
    input  logic [DATA_W-1:0]        exe2disp_data,
    input  logic                     exe2disp_valid_wr,
    input  logic                     exe2disp_valid,
    output logic                     disp2exe_alf,
    input  logic                     exe2disp_direction_req,
    input  logic [DIR_W-1:0]         exe2disp_direction,
    output logic [PORT_NUM-1:0]      disp2port_data_wr,
    output logic [DATA_W-1:0]        disp2port_data,
    output logic [PORT_NUM-1:0]      disp2port_valid_wr,
    output logic [PORT_NUM-1:0]      disp2port_valid,
    input  logic [PORT_NUM-1:0]      port2disp_alf,
    output logic [32*PORT_NUM-1:0]   disp_pkt_cnt,
    output logic [31:0]              disp_drop_cnt
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        TRANS_S = 2'd1,
        DROP_S  = 2'd2
    } state_t;

    state_t                state, nxt_state;
    logic [DIR_W-1:0]      sel, nxt_sel;
    logic [DATA_W-1:0]     nxt_data;
    logic [PORT_NUM-1:0]   nxt_data_wr, nxt_valid_wr, nxt_valid;
    logic [PORT_NUM-1:0]   dir_oh, sel_oh;
    logic [1:0]            pkt_site;
    logic                  dir_ok, head_ok, drop_inc;

    assign dir_ok   = 32'(exe2disp_direction) < PORT_NUM;
    assign dir_oh   = dir_ok ? (PORT_NUM'(1) << exe2disp_direction) : '0;
    assign sel_oh   = PORT_NUM'(1) << sel;
    assign pkt_site = exe2disp_data[DATA_W-1 -: 2];
    assign head_ok  = (pkt_site == 2'b01) && dir_ok;

    // Out-of-range directions go to the drop path, which never stalls execute.
    always_comb begin
        disp2exe_alf = 1'b1;
        if (exe2disp_direction_req) begin
            disp2exe_alf = dir_ok ? |(port2disp_alf & dir_oh) : 1'b0;
        end
    end

    // Next-state and next-output computation; strobes default low every cycle.
    always_comb begin
        nxt_state    = state;
        nxt_sel      = sel;
        nxt_data     = disp2port_data;
        nxt_data_wr  = '0;
        nxt_valid_wr = '0;
        nxt_valid    = disp2port_valid;
        drop_inc     = 1'b0;
        case (state)
            IDLE_S: begin
                if (exe2disp_data_wr) begin
                    nxt_sel = exe2disp_direction;
                    if (head_ok) begin
                        nxt_data    = exe2disp_data;
                        nxt_data_wr = dir_oh;
                        if (exe2disp_valid_wr) begin
                            nxt_valid_wr = dir_oh;
                            nxt_valid    = (disp2port_valid & ~dir_oh) |
                                           (dir_oh & {PORT_NUM{exe2disp_valid}});
                        end else begin
                            nxt_state = TRANS_S;
                        end
                    end else if (exe2disp_valid_wr) begin
                        drop_inc = 1'b1;
                    end else begin
                        nxt_state = DROP_S;
                    end
                end
            end
            TRANS_S: begin
                nxt_data    = exe2disp_data;
                nxt_data_wr = exe2disp_data_wr ? sel_oh : '0;
                if (exe2disp_valid_wr) begin
                    nxt_valid_wr = sel_oh;
                    nxt_valid    = (disp2port_valid & ~sel_oh) |
                                   (sel_oh & {PORT_NUM{exe2disp_valid}});
                    nxt_state    = IDLE_S;
                end
            end
            DROP_S: begin
                if (exe2disp_valid_wr) begin
                    drop_inc  = 1'b1;
                    nxt_state = IDLE_S;
                end
            end
            default: nxt_state = IDLE_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE_S;
            sel                <= '0;
            disp2port_data     <= '0;
            disp2port_data_wr  <= '0;
            disp2port_valid_wr <= '0;
            disp2port_valid    <= '0;
        end else begin
            state              <= nxt_state;
            sel                <= nxt_sel;
            disp2port_data     <= nxt_data;
            disp2port_data_wr  <= nxt_data_wr;
            disp2port_valid_wr <= nxt_valid_wr;
            disp2port_valid    <= nxt_valid;
        end
    end

`ifdef DISPATCH_CNT_EN
    logic [CNT_W-1:0] pkt_cnt [PORT_NUM];
    logic [CNT_W-1:0] drop_cnt;

    // Counters advance on the same edge that registers the output valid_wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                pkt_cnt[i] <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                if (nxt_valid_wr[i]) begin
                    pkt_cnt[i] <= pkt_cnt[i] + CNT_W'(1);
                end
            end
            if (drop_inc) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < int'(PORT_NUM); g++) begin : g_cnt
        assign disp_pkt_cnt[CNT_W*g +: CNT_W] = pkt_cnt[g];
    end
    assign disp_drop_cnt = drop_cnt;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign disp_pkt_cnt    = '0;
    assign disp_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_dispatch_mport.sv
// Directed bench for dispatch_mport: a per-cycle vector table on a 4-port instance plus
// hand sequences for out-of-range drop (3-port instance) and mid-packet reset.
module tb_dispatch_mport;

`ifdef DISPATCH_CNT_EN
    localparam int unsigned CNT = 1;
`else
    localparam int unsigned CNT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         data_wr = 1'b0;
    logic [133:0] data = '0;
    logic         valid_wr = 1'b0;
    logic         valid = 1'b0;
    logic         dir_req = 1'b0;
    logic [1:0]   dir = '0;
    logic [3:0]   alf = '0;

    logic         alf_o4, alf_o3;
    logic [3:0]   dwr4, vwr4, v4;
    logic [2:0]   dwr3, vwr3, v3;
    logic [133:0] d4, d3;
    logic [127:0] pcnt4;
    logic [95:0]  pcnt3;
    logic [31:0]  dcnt4, dcnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch_mport #(.PORT_NUM(4), .DIR_W(2), .DATA_W(134)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .exe2disp_data_wr(data_wr), .exe2disp_data(data),
        .exe2disp_valid_wr(valid_wr), .exe2disp_valid(valid),
        .disp2exe_alf(alf_o4),
        .exe2disp_direction_req(dir_req), .exe2disp_direction(dir),
        .disp2port_data_wr(dwr4), .disp2port_data(d4),
        .disp2port_valid_wr(vwr4), .disp2port_valid(v4),
        .port2disp_alf(alf),
        .disp_pkt_cnt(pcnt4), .disp_drop_cnt(dcnt4)
    );

    dispatch_mport #(.PORT_NUM(3), .DIR_W(2), .DATA_W(134)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .exe2disp_data_wr(data_wr), .exe2disp_data(data),
        .exe2disp_valid_wr(valid_wr), .exe2disp_valid(valid),
        .disp2exe_alf(alf_o3),
        .exe2disp_direction_req(dir_req), .exe2disp_direction(dir),
        .disp2port_data_wr(dwr3), .disp2port_data(d3),
        .disp2port_valid_wr(vwr3), .disp2port_valid(v3),
        .port2disp_alf(alf[2:0]),
        .disp_pkt_cnt(pcnt3), .disp_drop_cnt(dcnt3)
    );

    typedef struct {
        logic       dr;
        logic [1:0] site;
        logic       vw;
        logic       v;
        logic       req;
        logic [1:0] dir;
        logic [3:0] alf;
        logic [3:0] e_dwr;
        logic [3:0] e_vwr;
        logic [3:0] e_v;
        logic       e_alf;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(logic dr_i, logic [1:0] site_i, logic vw_i, logic v_i,
                                logic req_i, logic [1:0] dir_i, logic [3:0] alf_i,
                                logic [3:0] e_dwr_i, logic [3:0] e_vwr_i,
                                logic [3:0] e_v_i, logic e_alf_i);
        vec_t r;
        r.dr = dr_i; r.site = site_i; r.vw = vw_i; r.v = v_i; r.req = req_i;
        r.dir = dir_i; r.alf = alf_i; r.e_dwr = e_dwr_i; r.e_vwr = e_vwr_i;
        r.e_v = e_v_i; r.e_alf = e_alf_i;
        return r;
    endfunction

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dr_i, input logic [1:0] site_i, input logic vw_i,
                         input logic v_i, input logic req_i, input logic [1:0] dir_i,
                         input logic [3:0] alf_i, input int tag);
        data_wr  = dr_i;
        data     = {site_i, 4'h0, 128'(tag)};
        valid_wr = vw_i;
        valid    = v_i;
        dir_req  = req_i;
        dir      = dir_i;
        alf      = alf_i;
    endtask

    initial begin
        logic [133:0] exp_data;

        vecs[0]  = mk(0, 2'b00, 0, 0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[1]  = mk(0, 2'b00, 0, 0, 1, 2'd1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[2]  = mk(0, 2'b00, 0, 0, 1, 2'd3, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0);
        vecs[3]  = mk(0, 2'b00, 1, 1, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        vecs[4]  = mk(1, 2'b01, 0, 0, 1, 2'd2, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 0);
        vecs[5]  = mk(1, 2'b11, 0, 0, 0, 2'd2, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1);
        vecs[6]  = mk(1, 2'b10, 1, 1, 0, 2'd2, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1);
        vecs[7]  = mk(1, 2'b01, 0, 0, 0, 2'd1, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 1);
        vecs[8]  = mk(1, 2'b11, 0, 0, 0, 2'd3, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 1);
        vecs[9]  = mk(0, 2'b11, 0, 0, 0, 2'd3, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 1);
        vecs[10] = mk(1, 2'b10, 1, 0, 0, 2'd3, 4'b0000, 4'b0010, 4'b0010, 4'b0100, 1);
        vecs[11] = mk(1, 2'b01, 1, 1, 0, 2'd3, 4'b0000, 4'b1000, 4'b1000, 4'b1100, 1);
        vecs[12] = mk(1, 2'b11, 0, 0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 1);
        vecs[13] = mk(1, 2'b10, 1, 1, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 1);
        vecs[14] = mk(1, 2'b01, 0, 0, 0, 2'd0, 4'b0000, 4'b0001, 4'b0000, 4'b1100, 1);
        vecs[15] = mk(1, 2'b10, 1, 1, 0, 2'd0, 4'b0000, 4'b0001, 4'b0001, 4'b1101, 1);
        vecs[16] = mk(0, 2'b00, 0, 0, 0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dwr", 134'(dwr4), 134'(0));
        chk("rst_vwr", 134'(vwr4), 134'(0));
        chk("rst_v", 134'(v4), 134'(0));
        chk("rst_data", d4, 134'(0));
        chk("rst_pcnt", 134'(pcnt4), 134'(0));
        chk("rst_dcnt", 134'(dcnt4), 134'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].dr, vecs[i].site, vecs[i].vw, vecs[i].v, vecs[i].req,
                  vecs[i].dir, vecs[i].alf, 256 + i);
            exp_data = {vecs[i].site, 4'h0, 128'(256 + i)};
            #1;
            chk($sformatf("alf[%0d]", i), 134'(alf_o4), 134'(vecs[i].e_alf));
            @(posedge clk);
            #1;
            chk($sformatf("dwr[%0d]", i), 134'(dwr4), 134'(vecs[i].e_dwr));
            chk($sformatf("vwr[%0d]", i), 134'(vwr4), 134'(vecs[i].e_vwr));
            chk($sformatf("v[%0d]", i), 134'(v4), 134'(vecs[i].e_v));
            if (vecs[i].e_dwr != 4'b0000) begin
                chk($sformatf("data[%0d]", i), d4, exp_data);
            end
        end

        // One packet forwarded to each port, one malformed packet dropped
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("pcnt4[%0d]", p), 134'(pcnt4[32*p +: 32]), 134'(CNT));
        end
        chk("dcnt4", 134'(dcnt4), 134'(CNT));

        // Out-of-range direction on the 3-port instance
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 2'd0, 4'b0000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 2'b01, 0, 0, 1, 2'd3, 4'b1111, 512);
        #1;
        chk("oor_alf", 134'(alf_o3), 134'(0));
        @(posedge clk);
        #1;
        chk("oor_dwr_head", 134'(dwr3), 134'(0));
        @(negedge clk);
        drive(1, 2'b10, 1, 1, 1, 2'd3, 4'b1111, 513);
        @(posedge clk);
        #1;
        chk("oor_dwr_tail", 134'(dwr3), 134'(0));
        chk("oor_vwr_tail", 134'(vwr3), 134'(0));
        chk("oor_dcnt", 134'(dcnt3), 134'(CNT));
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 2'd0, 4'b0000, 0);

        // Reset pulsed mid-packet, remainder treated as a fresh (malformed) head
        @(negedge clk);
        drive(1, 2'b01, 0, 0, 0, 2'd2, 4'b0000, 768);
        @(posedge clk);
        #1;
        chk("mid_head_dwr", 134'(dwr4), 134'(4'b0100));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dwr", 134'(dwr4), 134'(0));
        chk("mid_rst_data", d4, 134'(0));
        chk("mid_rst_v", 134'(v4), 134'(0));
        chk("mid_rst_pcnt", 134'(pcnt4), 134'(0));
        chk("mid_rst_dcnt", 134'(dcnt4), 134'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 2'b11, 1, 1, 0, 2'd2, 4'b0000, 769);
        @(posedge clk);
        #1;
        chk("post_rst_dwr", 134'(dwr4), 134'(0));
        chk("post_rst_vwr", 134'(vwr4), 134'(0));
        chk("post_rst_dcnt", 134'(dcnt4), 134'(CNT));
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 2'd0, 4'b0000, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_mport.md
# dispatch_mport

Parametrised packet dispatcher that takes the execute stage's 134-bit packet stream and steers each whole packet to one of PORT_NUM output streams (port 0 is the up-CPU path by convention, ports 1..PORT_NUM-1 are down ports). It generalises the two-way up/down dispatch to N ports and adds the following:
- Registered valid pass-through.
- Per-port almost-full backpressure selection.
- Discard of packets with an out-of-range direction or a malformed head.

It sits between the execute module and the per-port output FIFOs in the UM_OPENFLOW pipeline.

## Interface
- PORT_NUM, 4: number of output streams, 2..16.
- DIR_W, 2: width of the direction field; 2^DIR_W ≥ PORT_NUM.
- DATA_W, 134: packet word width. Bits [133:132] are pkt_site, [131:128] are invalid, [127:0] are payload.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- exe2disp_data_wr  in  1  packet word strobe.
- exe2disp_data  in  DATA_W  packet word.
- exe2disp_valid_wr  in  1  end-of-packet valid strobe.
- exe2disp_valid  in  1  packet valid flag; 1 = keep, 0 = downstream drop.
- disp2exe_alf  out  1  almost-full toward execute; 1 = do not start a packet.
- exe2disp_direction_req  in  1  direction request qualifier.
- exe2disp_direction  in  DIR_W  target port index.
- disp2port_data_wr  out  PORT_NUM  per-port word strobe.
- disp2port_data  out  DATA_W  shared registered word.
- disp2port_valid_wr  out  PORT_NUM  per-port valid strobe.
- disp2port_valid  out  PORT_NUM  per-port registered valid flag.
- port2disp_alf  in  PORT_NUM  per-port almost-full.
- disp_pkt_cnt  out  32*PORT_NUM  forwarded-packet counters; port i occupies bits [32i+31:32i].
- disp_drop_cnt  out  32  discarded-packet counter.

## Operation
Backpressure (combinational):
- disp2exe_alf = port2disp_alf[exe2disp_direction] when exe2disp_direction_req=1 and exe2disp_direction < PORT_NUM.
- disp2exe_alf = 0 when exe2disp_direction_req=1 and the direction is out of range. The drop path always accepts.
- disp2exe_alf = 1 when exe2disp_direction_req=0.

FSM states: IDLE_S, TRANS_S, DROP_S.
- **IDLE_S, data_wr=1:**
  - Latch the target port sel ← exe2disp_direction.
  - If pkt_site=2'b01 and the direction is < PORT_NUM: register the word, assert data_wr[sel], and go to TRANS_S.
  - Otherwise: emit nothing and go to DROP_S.
  - If valid_wr=1 in the same cycle, the packet is a single cycle. Forward valid_wr[sel]/valid[sel] with it (or count a drop) and stay in IDLE_S.
- **IDLE_S, data_wr=0:** all strobes are 0. A stray valid_wr is ignored.
- **TRANS_S:** each cycle, register exe2disp_data. data_wr[sel] ← exe2disp_data_wr, valid_wr[sel] ← exe2disp_valid_wr, and valid[sel] ← exe2disp_valid when valid_wr=1. Go to IDLE_S on valid_wr=1; otherwise stay.
- **DROP_S:** no outputs. Go to IDLE_S on valid_wr=1 and increment disp_drop_cnt.
- Only the selected port's strobes are ever 1. All other ports' strobes are 0.
- disp2port_valid[i] holds its last value until the next valid_wr on port i.
- sel is frozen from head to valid_wr. Direction changes mid-packet are ignored.
- The block does not monitor alf mid-packet. Execute owns the headroom.
- Illegal state encoding goes to IDLE_S with all strobes 0.

## Timing
- Latency is 1 cycle, input to output, for data, data_wr, valid_wr and valid.
- A back-to-back packet may start in the cycle after valid_wr with no bubble.
- Reset values:
  - all strobes 0
  - disp2port_data 0
  - disp2port_valid 0
  - state IDLE_S
  - sel 0
  - all counters 0
- Reset asserted mid-packet clears all strobes at once. The remainder of the packet arriving after reset release is taken as a new head (dropped unless pkt_site=01).
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- A counter increments in the cycle the output valid_wr is registered.

## Configuration
- DISPATCH_CNT_EN defined: disp_pkt_cnt[i] increments on each registered valid_wr on port i. disp_drop_cnt increments on each discarded packet.
- DISPATCH_CNT_EN undefined: both counter ports remain but are tied to 0, and no counter registers are built. Forwarding behaviour is identical.

## Test plan
- **Port forwarding:** PORT_NUM=4, direction=2, a 3-word packet (site 01/11/10), valid_wr with the tail, valid=1 -> the same words appear on disp2port_data with data_wr[2] one cycle later; valid_wr[2]=1 and valid[2]=1 on the tail; all other strobes 0; disp_pkt_cnt[2]=1.
- **Backpressure select:** direction_req=1, direction=1, port2disp_alf=4'b0010 -> disp2exe_alf=1. With direction=3 -> 0. With direction_req=0 -> 1.
- **Out-of-range direction:** PORT_NUM=3, DIR_W=2, direction=3 -> no output strobes and disp2exe_alf=0. A 2-word packet increments disp_drop_cnt to 1.
- **Malformed head:** the first word has site 2'b11 with direction=0 -> the whole packet is discarded up to valid_wr, drop count +1; the next well-formed packet to port 0 is forwarded intact.
- **Mid-packet behaviour:**
  - The direction changes mid-packet -> all words stay on the latched port.
  - The next packet, started the cycle after valid_wr, goes to the new port with no gap.
  - rst_n pulsed low mid-packet -> all outputs are 0 asynchronously and the counters clear.
